// File: rtl/instr_queue.sv
// Fetch-to-decode decoupling queue: circular buffer taking up to FETCH_WIDTH
// compacted entries per cycle and presenting up to DECODE_WIDTH in program order.
package instr_queue_pkg;
  typedef struct packed {
    logic        valid;
    logic        excp;
    logic [3:0]  excp_num;
    logic [31:0] pc;
    logic [31:0] instr;
  } instr_buffer_info_t;
endpackage

module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int FETCH_WIDTH  = 4,
  parameter int DECODE_WIDTH = 2,
  parameter int DEPTH        = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    flush_i,
  input  logic                                    frontend_valid_i,
  input  instr_buffer_info_t [FETCH_WIDTH-1:0]    frontend_instr_i,
  output logic                                    frontend_ready_o,
  output instr_buffer_info_t [DECODE_WIDTH-1:0]   decode_instr_o,
  output logic [DECODE_WIDTH-1:0]                 decode_valid_o,
  input  logic                                    decode_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]              count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  instr_buffer_info_t ram [DEPTH];
  logic [PTR_W-1:0]   head, tail;
  logic [CNT_W-1:0]   count;
  logic               push, pop;
  logic [CNT_W-1:0]   push_n, pop_n;
  logic [PTR_W-1:0]   wr_idx [FETCH_WIDTH];
  logic [FETCH_WIDTH-1:0] valid_mask;

  function automatic logic contiguous(input logic [FETCH_WIDTH-1:0] v);
    return (v & (v + FETCH_WIDTH'(1))) == '0;
  endfunction

  // Ready looks only at the registered count, so a same-cycle pop never helps.
  assign frontend_ready_o = !rst && (count <= CNT_W'(DEPTH - FETCH_WIDTH));
  assign push             = frontend_valid_i && frontend_ready_o && !flush_i;
  assign pop              = decode_ready_i && !flush_i;
  assign count_o          = count;

  // Valid slots are packed into consecutive RAM locations starting at tail.
  always_comb begin
    push_n = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      valid_mask[k] = frontend_instr_i[k].valid;
      wr_idx[k]     = tail + PTR_W'(push_n);
      if (frontend_instr_i[k].valid) push_n = push_n + CNT_W'(1);
    end
  end

  always_comb begin
    pop_n = '0;
    for (int k = 0; k < DECODE_WIDTH; k++) begin
      decode_instr_o[k] = ram[head + PTR_W'(k)];
      decode_valid_o[k] = CNT_W'(k) < count;
      // An exception at the head issues on its own.
      if (k > 0 && ram[head].excp) decode_valid_o[k] = 1'b0;
      if (decode_valid_o[k]) pop_n = pop_n + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(push_n);
      if (pop)  head <= head + PTR_W'(pop_n);
      count <= count + (push ? push_n : CNT_W'(0)) - (pop ? pop_n : CNT_W'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        if (frontend_instr_i[k].valid) ram[wr_idx[k]] <= frontend_instr_i[k];
      end
    end
  end

  a_contiguous_slots: assert property (@(posedge clk) disable iff (rst)
    frontend_valid_i |-> contiguous(valid_mask));

endmodule

// File: tb/tb_instr_queue.sv
// Bench for instr_queue: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_instr_queue;
  import instr_queue_pkg::*;

  localparam int FW = 4;
  localparam int DW = 2;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst, flush_i, frontend_valid_i, decode_ready_i;
  instr_buffer_info_t [FW-1:0] frontend_instr_i;
  logic frontend_ready_o;
  instr_buffer_info_t [DW-1:0] decode_instr_o;
  logic [DW-1:0] decode_valid_o;
  logic [4:0] count_o;

  instr_queue #(.FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .frontend_valid_i(frontend_valid_i), .frontend_instr_i(frontend_instr_i),
    .frontend_ready_o(frontend_ready_o), .decode_instr_o(decode_instr_o),
    .decode_valid_o(decode_valid_o), .decode_ready_i(decode_ready_i),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;
  instr_buffer_info_t mq[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_n();
    int n;
    n = (mq.size() < DW) ? mq.size() : DW;
    if (n > 1 && mq[0].excp) n = 1;
    return n;
  endfunction

  function automatic bit model_ready();
    return !rst && (DEPTH - mq.size() >= FW);
  endfunction

  // Reference model: advances on each clock edge from the inputs held across it.
  always @(posedge clk) begin
    int n;
    bit rdy;
    if (rst || flush_i) begin
      mq.delete();
    end else begin
      n = model_n();
      rdy = model_ready();
      if (decode_ready_i) repeat (n) void'(mq.pop_front());
      if (frontend_valid_i && rdy)
        for (int k = 0; k < FW; k++)
          if (frontend_instr_i[k].valid) mq.push_back(frontend_instr_i[k]);
    end
  end

  // Compare process: outputs against the model on every falling edge.
  always @(negedge clk) begin
    int n;
    logic [1:0] m;
    if (chk_en) begin
      n = model_n();
      m = (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
      check("count", 128'(count_o), 128'(mq.size()));
      check("ready", 128'(frontend_ready_o), 128'(model_ready()));
      check("dvalid", 128'(decode_valid_o), 128'(m));
      for (int k = 0; k < n; k++)
        check($sformatf("slot%0d", k), 128'(decode_instr_o[k]), 128'(mq[k]));
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic set_group(input int nvalid, input logic [31:0] pc0, input bit ex0);
    instr_buffer_info_t g [FW];
    for (int k = 0; k < FW; k++) begin
      g[k].valid    = (k < nvalid);
      g[k].excp     = (k == 0) && ex0;
      g[k].excp_num = ((k == 0) && ex0) ? 4'b0001 : 4'b0000;
      g[k].pc       = pc0 + 32'(4 * k);
      g[k].instr    = $urandom;
      frontend_instr_i[k] = g[k];
    end
  endtask

  task automatic empty_queue();
    flush_i = 1'b1;
    frontend_valid_i = 1'b0;
    step();
    flush_i = 1'b0;
  endtask

  initial begin
    logic [31:0] pc;
    int nv;
    rst = 1'b1; flush_i = 1'b0; frontend_valid_i = 1'b0; decode_ready_i = 1'b0;
    set_group(0, 32'h0, 1'b0);
    step();
    chk_en = 1'b1;
    step();
    check("rst_ready", 128'(frontend_ready_o), 128'(0));
    check("rst_dvalid", 128'(decode_valid_o), 128'(0));
    rst = 1'b0;
    #1;
    check("post_rst_ready", 128'(frontend_ready_o), 128'(1));
    check("post_rst_count", 128'(count_o), 128'(0));

    // Single full group drained two at a time.
    set_group(4, 32'h1c00_0000, 1'b0);
    frontend_valid_i = 1'b1; decode_ready_i = 1'b1;
    step();
    frontend_valid_i = 1'b0;
    check("g1_pc0", 128'(decode_instr_o[0].pc), 128'(32'h1c00_0000));
    check("g1_pc1", 128'(decode_instr_o[1].pc), 128'(32'h1c00_0004));
    step();
    check("g2_pc0", 128'(decode_instr_o[0].pc), 128'(32'h1c00_0008));
    check("g2_pc1", 128'(decode_instr_o[1].pc), 128'(32'h1c00_000c));
    step();
    check("g3_count", 128'(count_o), 128'(0));
    check("g3_dvalid", 128'(decode_valid_o), 128'(0));

    // Fill to capacity with decode stalled, then drain.
    decode_ready_i = 1'b0; frontend_valid_i = 1'b1;
    for (int g = 0; g < 6; g++) begin
      set_group(4, 32'h2000_0000 + 32'(16 * g), 1'b0);
      step();
    end
    check("full_count", 128'(count_o), 128'(16));
    check("full_ready", 128'(frontend_ready_o), 128'(0));
    frontend_valid_i = 1'b0; decode_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_pc0", 128'(decode_instr_o[0].pc), 128'(32'h2000_0000 + 32'(8 * i)));
      check("drain_pc1", 128'(decode_instr_o[1].pc), 128'(32'h2000_0004 + 32'(8 * i)));
      step();
    end
    check("drained_count", 128'(count_o), 128'(0));

    // Partial groups 0011, 0111, 0000.
    decode_ready_i = 1'b0; frontend_valid_i = 1'b1;
    set_group(2, 32'h3000_0000, 1'b0); step();
    check("part2_count", 128'(count_o), 128'(2));
    set_group(3, 32'h3000_0008, 1'b0); step();
    check("part3_count", 128'(count_o), 128'(5));
    set_group(0, 32'h3000_0100, 1'b0); step();
    check("part0_count", 128'(count_o), 128'(5));
    frontend_valid_i = 1'b0; decode_ready_i = 1'b1;
    check("part_pc0", 128'(decode_instr_o[0].pc), 128'(32'h3000_0000));
    step();
    check("part_pc2", 128'(decode_instr_o[0].pc), 128'(32'h3000_0008));
    check("part_pc3", 128'(decode_instr_o[1].pc), 128'(32'h3000_000c));
    empty_queue();

    // Exception at head issues alone.
    decode_ready_i = 1'b0; frontend_valid_i = 1'b1;
    set_group(2, 32'h4000_0000, 1'b1);
    step();
    frontend_valid_i = 1'b0;
    check("excp_dvalid", 128'(decode_valid_o), 128'(2'b01));
    check("excp_num", 128'(decode_instr_o[0].excp_num), 128'(4'b0001));
    decode_ready_i = 1'b1;
    step();
    check("after_excp_pc", 128'(decode_instr_o[0].pc), 128'(32'h4000_0004));
    check("after_excp_dvalid", 128'(decode_valid_o), 128'(2'b01));
    empty_queue();

    // Flush with count 10, racing a push and a pop.
    decode_ready_i = 1'b0; frontend_valid_i = 1'b1;
    set_group(4, 32'h5000_0000, 1'b0); step();
    set_group(4, 32'h5000_0010, 1'b0); step();
    set_group(2, 32'h5000_0020, 1'b0); step();
    check("pre_flush_count", 128'(count_o), 128'(10));
    set_group(4, 32'h5000_0028, 1'b0);
    flush_i = 1'b1; decode_ready_i = 1'b1;
    step();
    flush_i = 1'b0; frontend_valid_i = 1'b0;
    check("flush_count", 128'(count_o), 128'(0));
    check("flush_dvalid", 128'(decode_valid_o), 128'(0));
    check("flush_ready", 128'(frontend_ready_o), 128'(1));

    // Randomized traffic across many pointer wraps.
    pc = 32'h6000_0000;
    for (int c = 0; c < 3000; c++) begin
      nv = $urandom_range(0, FW);
      set_group(nv, pc, ($urandom_range(0, 9) == 0));
      frontend_valid_i = ($urandom_range(0, 9) < 7);
      decode_ready_i   = ($urandom_range(0, 9) < 6);
      flush_i          = ($urandom_range(0, 49) == 0);
      rst              = ($urandom_range(0, 199) == 0);
      if (frontend_valid_i && frontend_ready_o) pc = pc + 32'(4 * nv);
      step();
    end
    rst = 1'b0; flush_i = 1'b0; frontend_valid_i = 1'b0;
    step();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
